// File: rtl/fifo_seq_pkg.sv
// ============================================================================
// Module  : fifo_seq_pkg
// Brief   : Shared state encoding and default widths for the readout sequencer
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_seq_pkg;

  localparam int DEF_N        = 6;
  localparam int DEF_FRAMES_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_FRAME = 3'd1,
    ST_READ       = 3'd2,
    ST_DRAIN      = 3'd3,
    ST_FINISH     = 3'd4
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/slot_index_counter.sv
// ============================================================================
// Module  : slot_index_counter
// Brief   : Wrapping slot index counter with clear, enable and last-slot flag
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module slot_index_counter #(
  parameter int N = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  input  logic [N-1:0] wrap,
  output logic [N-1:0] index,
  output logic         is_last
);

  logic [N-1:0] r_index;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_index <= '0;
    end else if (clear) begin
      r_index <= '0;
    end else if (enable) begin
      r_index <= is_last ? '0 : r_index + 1'b1;
    end
  end

  assign index   = r_index;
  assign is_last = (r_index == wrap);

endmodule

`default_nettype wire

// File: rtl/fifo_readout_sequencer.sv
// ============================================================================
// Module  : fifo_readout_sequencer
// Brief   : Frame-by-frame readout of a slot memory with valid/ready output
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_readout_sequencer
  import fifo_seq_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int FRAMES_W = DEF_FRAMES_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [N-1:0]        maxindex,
  input  logic [FRAMES_W-1:0] nframes,
  input  logic                frame_avail,
  output logic                rd_en,
  output logic [N-1:0]        rd_index,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                frame_ack,
  output logic [FRAMES_W-1:0] frame_count,
  output logic                busy,
  output logic                done
);

  seq_state_t          r_state;
  seq_state_t          w_state_nxt;
  logic [N-1:0]        r_maxindex;
  logic [FRAMES_W-1:0] r_nframes;
  logic [FRAMES_W-1:0] r_frame_count;
  logic [FRAMES_W-1:0] w_count_inc;
  logic                r_out_valid;
  logic                w_accept;
  logic                w_rd_en;
  logic                w_frame_ack;
  logic                w_done;
  logic                w_clear;
  logic                w_is_last;

  assign w_count_inc = r_frame_count + 1'b1;

  // Abort overrides every other decision, including a same-cycle start.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_rd_en     = 1'b0;
    w_frame_ack = 1'b0;
    w_done      = 1'b0;
    if (abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_accept    = 1'b1;
            w_state_nxt = ST_WAIT_FRAME;
          end
        end
        ST_WAIT_FRAME: begin
          if (frame_avail) begin
            w_state_nxt = ST_READ;
          end
        end
        ST_READ: begin
          w_rd_en = !r_out_valid || out_ready;
          if (w_rd_en && w_is_last) begin
            w_state_nxt = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (r_out_valid && out_ready) begin
            w_frame_ack = 1'b1;
            if ((r_nframes != '0) && (w_count_inc == r_nframes)) begin
              w_state_nxt = ST_FINISH;
            end else begin
              w_state_nxt = ST_WAIT_FRAME;
            end
          end
        end
        ST_FINISH: begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_maxindex    <= '0;
      r_nframes     <= '0;
      r_frame_count <= '0;
    end else if (w_accept) begin
      r_maxindex    <= maxindex;
      r_nframes     <= nframes;
      r_frame_count <= '0;
    end else if (w_frame_ack) begin
      r_frame_count <= w_count_inc;
    end
  end

  // One word in flight at most: a fresh strobe refills the slot being drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
    end else if (abort) begin
      r_out_valid <= 1'b0;
    end else if (w_rd_en) begin
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign w_clear = abort || (r_state == ST_IDLE) || (r_state == ST_WAIT_FRAME);

  slot_index_counter #(
    .N(N)
  ) u_slot_index (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_clear),
    .enable (w_rd_en),
    .wrap   (r_maxindex),
    .index  (rd_index),
    .is_last(w_is_last)
  );

  assign rd_en       = w_rd_en;
  assign out_valid   = r_out_valid;
  assign frame_ack   = w_frame_ack;
  assign frame_count = r_frame_count;
  assign busy        = (r_state != ST_IDLE);
  assign done        = w_done;

endmodule

`default_nettype wire

// File: tb/tb_fifo_readout_sequencer.sv
// ============================================================================
// Module  : tb_fifo_readout_sequencer
// Brief   : Scoreboard bench for the readout sequencer with a 1-cycle memory model
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_readout_sequencer;

  localparam int N  = 6;
  localparam int FW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [N-1:0]  maxindex;
  logic [FW-1:0] nframes;
  logic          frame_avail;
  logic          rd_en;
  logic [N-1:0]  rd_index;
  logic          out_valid;
  logic          out_ready;
  logic          frame_ack;
  logic [FW-1:0] frame_count;
  logic          busy;
  logic          done;

  fifo_readout_sequencer #(.N(N), .FRAMES_W(FW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .maxindex(maxindex), .nframes(nframes), .frame_avail(frame_avail),
    .rd_en(rd_en), .rd_index(rd_index), .out_valid(out_valid),
    .out_ready(out_ready), .frame_ack(frame_ack), .frame_count(frame_count),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    bit last;
  } exp_t;

  exp_t       sb[$];
  int         vectors     = 0;
  int         miscompares = 0;
  int         acks_seen   = 0;
  int         done_seen   = 0;
  int         ready_mode  = 0;
  bit         avail_rand  = 1'b0;
  logic       avail_level = 1'b0;
  logic [N-1:0] mem_q = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input string what);
    vectors++;
    miscompares++;
    $display("FAIL %s: %s (t=%0t)", name, what, $time);
  endtask

  // Memory with one-cycle read latency; each word carries its own slot index.
  always @(posedge clk) if (rd_en) mem_q <= rd_index;

  // Monitor: pops the scoreboard on every handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (done) done_seen++;
      if (out_valid && !out_ready) chk("no_rd_while_stalled", rd_en, 0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          fail("unexpected_word", $sformatf("index %0d delivered with empty scoreboard", mem_q));
        end else begin
          e = sb.pop_front();
          chk("word_index", mem_q, e.idx);
          chk("frame_ack_on_last", frame_ack, e.last);
        end
        if (frame_ack) acks_seen++;
      end else if (frame_ack) begin
        fail("spurious_frame_ack", "frame_ack without handshake");
      end
    end
  end

  // Downstream ready and upstream frame_avail drivers.
  initial begin
    out_ready   = 1'b1;
    frame_avail = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      frame_avail = avail_rand ? 1'($urandom_range(0, 1)) : avail_level;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run(input int m, input int f);
    for (int fr = 0; fr < f; fr++)
      for (int i = 0; i <= m; i++) begin
        exp_t e;
        e.idx  = i;
        e.last = (i == m);
        sb.push_back(e);
      end
  endtask

  task automatic pulse_start(input int m, input int f);
    maxindex = N'(m);
    nframes  = FW'(f);
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int a0, input int f, input string tag);
    int c;
    for (c = 0; c < 4000 && done_seen == d0; c++) tick();
    if (done_seen == d0) begin
      fail({tag, "_timeout"}, "done never seen");
    end else begin
      @(negedge clk);
      chk({tag, "_busy_after_done"}, busy, 0);
      chk({tag, "_frame_count"}, frame_count, f);
      chk({tag, "_acks"}, acks_seen - a0, f);
      chk({tag, "_sb_empty"}, sb.size(), 0);
      tick();
      tick();
      chk({tag, "_done_once"}, done_seen - d0, 1);
    end
  endtask

  task automatic run(input int m, input int f, input string tag);
    int d0 = done_seen;
    int a0 = acks_seen;
    push_run(m, f);
    pulse_start(m, f);
    wait_done(d0, a0, f, tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int a0;
    int c;
    rst      = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    maxindex = '0;
    nframes  = '0;
    repeat (3) @(negedge clk);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_index", rd_index, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_frame_ack", frame_ack, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    tick();
    rst = 1'b0;
    tick();

    // Full-rate, then stalled every other cycle.
    avail_level = 1'b1;
    ready_mode  = 0;
    run(3, 2, "basic");
    ready_mode = 1;
    run(3, 2, "toggle");
    ready_mode = 0;

    // Busy latency, frame_avail held low, start while busy.
    avail_level = 1'b0;
    tick();
    d0 = done_seen;
    a0 = acks_seen;
    push_run(2, 1);
    maxindex = 6'd2;
    nframes  = 16'd1;
    start    = 1'b1;
    @(negedge clk);
    chk("busy_before_edge", busy, 0);
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", busy, 1);
    tick();
    pulse_start(5, 3);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("wait_no_rd", rd_en, 0);
      chk("wait_busy", busy, 1);
      tick();
    end
    avail_level = 1'b1;
    @(negedge clk);
    chk("avail_edge_no_rd", rd_en, 0);
    @(negedge clk);
    chk("first_rd_en", rd_en, 1);
    chk("first_rd_index", rd_index, 0);
    tick();
    wait_done(d0, a0, 1, "waitavail");

    // start together with abort while idle.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("start_abort_busy", busy, 0);
      tick();
    end

    // Continuous single-slot frames, aborted after five.
    d0 = done_seen;
    a0 = acks_seen;
    push_run(0, 5);
    pulse_start(0, 0);
    for (c = 0; c < 500 && acks_seen - a0 < 5; c++) tick();
    if (acks_seen - a0 < 5) fail("cont_timeout", "five frame_acks not seen");
    abort = 1'b1;
    @(negedge clk);
    chk("abort_no_rd", rd_en, 0);
    chk("abort_no_ack", frame_ack, 0);
    tick();
    abort = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("cont_frame_count", frame_count, 5);
    chk("cont_acks", acks_seen - a0, 5);
    chk("cont_no_done", done_seen - d0, 0);
    chk("cont_sb_empty", sb.size(), 0);
    tick();

    // Asynchronous reset in the middle of a frame.
    push_run(7, 1);
    pulse_start(7, 1);
    for (c = 0; c < 200 && !(rd_en && rd_index == 6'd3); c++) tick();
    chk("midread_reached_3", rd_index, 3);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_rd_en", rd_en, 0);
    chk("arst_rd_index", rd_index, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_frame_count", frame_count, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    sb.delete();
    tick();
    tick();
    rst = 1'b0;
    tick();
    run(2, 1, "after_rst");

    // Randomized runs.
    ready_mode = 2;
    avail_rand = 1'b1;
    for (int r = 0; r < 12; r++)
      run(int'($urandom_range(0, 7)), int'($urandom_range(1, 3)), "rand");
    ready_mode = 0;
    for (int r = 0; r < 4; r++)
      run(int'($urandom_range(0, 7)), int'($urandom_range(1, 3)), "rand_full");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
